// File: rtl/wb_arbiter.sv
// Write-back arbiter: three result sources, each buffered in a private FIFO,
// merged round-robin onto a single registered register-file write port.
module wb_arbiter #(
  parameter int DW     = 32,
  parameter int RF_NUM = 32,
  parameter int DEPTH  = 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DW-1:0]     alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        mem_rd,
  input  logic [DW-1:0]     mem_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [4:0]        mdu_rd,
  input  logic [DW-1:0]     mdu_data,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [DW-1:0]     wb_data,
  output logic [RF_NUM-1:0] pend_mask
);

  localparam int NSRC = 3;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [NSRC-1:0]  src_valid_s;
  logic [4:0]       src_rd_s   [NSRC];
  logic [DW-1:0]    src_data_s [NSRC];

  logic [DEPTH-1:0] vld_q  [NSRC];
  logic [DEPTH-1:0] vld_d  [NSRC];
  logic [PW-1:0]    wptr_q [NSRC];
  logic [PW-1:0]    wptr_d [NSRC];
  logic [PW-1:0]    rptr_q [NSRC];
  logic [PW-1:0]    rptr_d [NSRC];
  logic [4:0]       ent_rd_q   [NSRC][DEPTH];
  logic [4:0]       ent_rd_d   [NSRC][DEPTH];
  logic [DW-1:0]    ent_data_q [NSRC][DEPTH];
  logic [DW-1:0]    ent_data_d [NSRC][DEPTH];

  logic [1:0]       last_q, last_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [DW-1:0]    wb_data_q, wb_data_d;

  logic [NSRC-1:0]  full_s, nonempty_s, ready_s, push_s;
  logic             grant_valid_s;
  logic [1:0]       grant_idx_s;
  logic [1:0]       cand_s [3];
  logic [RF_NUM-1:0] pend_mask_s;

  assign src_valid_s   = {mdu_valid, mem_valid, alu_valid};
  assign src_rd_s[0]   = alu_rd;
  assign src_rd_s[1]   = mem_rd;
  assign src_rd_s[2]   = mdu_rd;
  assign src_data_s[0] = alu_data;
  assign src_data_s[1] = mem_data;
  assign src_data_s[2] = mdu_data;

  // Ready depends only on stored occupancy and reset; rd==0 pushes are dropped.
  always_comb begin
    full_s     = '0;
    nonempty_s = '0;
    ready_s    = '0;
    push_s     = '0;
    for (int s = 0; s < NSRC; s++) begin
      full_s[s]     = &vld_q[s];
      nonempty_s[s] = |vld_q[s];
      ready_s[s]    = ~areset & ~full_s[s];
      push_s[s]     = src_valid_s[s] & ready_s[s] & (src_rd_s[s] != 5'd0);
    end
  end

  assign alu_ready = ready_s[0];
  assign mem_ready = ready_s[1];
  assign mdu_ready = ready_s[2];

  always_comb begin
    case (last_q)
      2'd0: begin
        cand_s[0] = 2'd1; cand_s[1] = 2'd2; cand_s[2] = 2'd0;
      end
      2'd1: begin
        cand_s[0] = 2'd2; cand_s[1] = 2'd0; cand_s[2] = 2'd1;
      end
      default: begin
        cand_s[0] = 2'd0; cand_s[1] = 2'd1; cand_s[2] = 2'd2;
      end
    endcase
    grant_valid_s = 1'b1;
    grant_idx_s   = cand_s[0];
    if (nonempty_s[cand_s[0]]) begin
      grant_idx_s = cand_s[0];
    end else if (nonempty_s[cand_s[1]]) begin
      grant_idx_s = cand_s[1];
    end else if (nonempty_s[cand_s[2]]) begin
      grant_idx_s = cand_s[2];
    end else begin
      grant_valid_s = 1'b0;
      grant_idx_s   = last_q;
    end
  end

  // Push and pop never target the same slot: a popped FIFO is non-empty and not full.
  always_comb begin
    vld_d      = vld_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    for (int s = 0; s < NSRC; s++) begin
      if (push_s[s]) begin
        ent_rd_d[s][wptr_q[s]]   = src_rd_s[s];
        ent_data_d[s][wptr_q[s]] = src_data_s[s];
        vld_d[s][wptr_q[s]]      = 1'b1;
        wptr_d[s]                = ptr_inc(wptr_q[s]);
      end else begin
        wptr_d[s] = wptr_q[s];
      end
      if (grant_valid_s && (grant_idx_s == 2'(s))) begin
        vld_d[s][rptr_q[s]] = 1'b0;
        rptr_d[s]           = ptr_inc(rptr_q[s]);
      end else begin
        rptr_d[s] = rptr_q[s];
      end
    end
  end

  always_comb begin
    wb_en_d = grant_valid_s;
    if (grant_valid_s) begin
      wb_rd_d   = ent_rd_q[grant_idx_s][rptr_q[grant_idx_s]];
      wb_data_d = ent_data_q[grant_idx_s][rptr_q[grant_idx_s]];
      last_d    = grant_idx_s;
    end else begin
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      last_d    = last_q;
    end
  end

  // Pending mask is a decode of stored entries, so it clears as the write is registered.
  always_comb begin
    pend_mask_s = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int r = 0; r < RF_NUM; r++) begin
          pend_mask_s[r] = pend_mask_s[r] | (vld_q[s][e] & (ent_rd_q[s][e] == 5'(r)));
        end
      end
    end
    pend_mask_s[0] = 1'b0;
  end

  assign pend_mask = pend_mask_s;
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int s = 0; s < NSRC; s++) begin
        vld_q[s]  <= '0;
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
      end
      last_q    <= 2'd2;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
    end else begin
      vld_q      <= vld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      last_q     <= last_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule
